// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between the fetch and load/store ports
// Each access runs IDLE -> BUSY -> DONE; served flags stop a port being re-granted until the pipeline advances.
module mem_port_arbiter #(
    parameter int MAX_WAIT   = 255,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_rdata_o,
    output logic        inst_valid_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic [3:0]  data_wmask_i,
    output logic [31:0] data_rdata_o,
    output logic        data_valid_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wmask_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_error_o,
    output logic        want_stall_o
);

    localparam int CW = ($clog2(MAX_WAIT) > 8) ? $clog2(MAX_WAIT) : 8;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic          inst_done_q, inst_done_d;
    logic          data_done_q, data_done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wmask_q, wmask_d;
    logic          we_q, we_d;

    logic inst_elig, data_elig, grant_data, busy;

    assign inst_elig  = inst_req_i & ~inst_done_q;
    assign data_elig  = data_req_i & ~data_done_q;
    assign grant_data = data_elig & (DATA_FIRST | ~inst_elig);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            inst_done_q <= 1'b0;
            data_done_q <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            inst_done_q <= inst_done_d;
            data_done_q <= data_done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
            we_q        <= we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        inst_done_d = inst_done_q;
        data_done_d = data_done_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        we_d        = we_q;
        case (state_q)
            IDLE: begin
                if (inst_elig | data_elig) begin
                    wait_d = '0;
                    err_d  = 1'b0;
                    if (grant_data) begin
                        state_d = BUSY_D;
                        addr_d  = data_addr_i;
                        wdata_d = data_wdata_i;
                        we_d    = data_we_i;
                        wmask_d = data_we_i ? data_wmask_i : 4'b0000;
                    end else begin
                        state_d = BUSY_I;
                        addr_d  = inst_addr_i;
                        wdata_d = '0;
                        we_d    = 1'b0;
                        wmask_d = 4'b0000;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus_ready_i) begin
                    rdata_d = we_q ? 32'h0 : bus_rdata_i;
                    err_d   = 1'b0;
                    state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
                end else if (wait_q == WAIT_LAST) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE_I: begin
                inst_done_d = 1'b1;
                state_d     = IDLE;
            end
            DONE_D: begin
                data_done_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A released stall means the pipeline advanced, so the next request is new work.
        if (!want_stall_o) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end
    end

    always_comb begin
        busy         = (state_q == BUSY_I) || (state_q == BUSY_D);
        inst_valid_o = (state_q == DONE_I);
        data_valid_o = (state_q == DONE_D);
        inst_rdata_o = inst_valid_o ? rdata_q : 32'h0;
        data_rdata_o = data_valid_o ? rdata_q : 32'h0;
        bus_error_o  = (inst_valid_o | data_valid_o) & err_q;
        bus_req_o    = busy;
        bus_we_o     = busy & we_q;
        bus_addr_o   = busy ? addr_q : 32'h0;
        bus_wdata_o  = busy ? wdata_q : 32'h0;
        bus_wmask_o  = busy ? wmask_q : 4'b0000;
        want_stall_o = (data_req_i & ~data_done_q & ~data_valid_o)
                     | (inst_req_i & ~inst_done_q & ~inst_valid_o);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

    localparam int MAX_WAIT   = 4;
    localparam bit DATA_FIRST = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, data_we, bus_ready;
    logic [31:0] inst_addr, data_addr, data_wdata, bus_rdata;
    logic [3:0]  data_wmask;
    logic [31:0] inst_rdata, data_rdata, bus_addr, bus_wdata;
    logic        inst_valid, data_valid, bus_req, bus_we, bus_error, want_stall;
    logic [3:0]  bus_wmask;

    int n_vec = 0;
    int n_bad = 0;
    int exp_txn = 0;
    int bus_txn = 0;
    logic prev_breq = 1'b0;
    bit force_rd = 1'b0;
    logic [31:0] forced_rd = 32'h0;

    mem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_FIRST(DATA_FIRST)) dut (
        .clock_i(clk), .reset_i(rst),
        .inst_req_i(inst_req), .inst_addr_i(inst_addr),
        .inst_rdata_o(inst_rdata), .inst_valid_o(inst_valid),
        .data_req_i(data_req), .data_we_i(data_we), .data_addr_i(data_addr),
        .data_wdata_i(data_wdata), .data_wmask_i(data_wmask),
        .data_rdata_o(data_rdata), .data_valid_o(data_valid),
        .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_wmask_o(bus_wmask),
        .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata),
        .bus_error_o(bus_error), .want_stall_o(want_stall)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_req && !prev_breq) bus_txn++;
        prev_breq = bus_req;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One pipeline step: requests are presented together and held until want_stall drops.
    task automatic run_op(input bit has_i, input bit has_d, input logic [31:0] ia, input bit dwe,
                          input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dm,
                          input int lat_i, input int lat_d, input bit drop);
        int nports, lat, nb;
        bit first_d, port_d, last, dropped, tmo, is_store;
        logic [31:0] cap, exp_rd;
        @(posedge clk); #1;
        inst_req = has_i; inst_addr = ia;
        data_req = has_d; data_we = dwe; data_addr = da; data_wdata = dwd; data_wmask = dm;
        bus_ready = 1'b0;
        nports  = int'(has_i) + int'(has_d);
        first_d = has_d && (DATA_FIRST || !has_i);
        dropped = 1'b0;
        cap     = 32'h0;
        if (nports == 0) begin
            @(negedge clk);
            check("idle_stall", 32'(want_stall), 32'h0);
            check("idle_breq", 32'(bus_req), 32'h0);
            return;
        end
        for (int s = 0; s < nports; s++) begin
            port_d   = (s == 0) ? first_d : !first_d;
            last     = (s == nports - 1);
            is_store = port_d && dwe;
            if (s > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            check("arb_breq", 32'(bus_req), 32'h0);
            check("arb_stall", 32'(want_stall), 32'h1);
            lat = port_d ? lat_d : lat_i;
            tmo = (lat >= MAX_WAIT);
            nb  = tmo ? MAX_WAIT : lat + 1;
            for (int k = 0; k < nb; k++) begin
                @(posedge clk); #1;
                if (drop && nports == 1 && k == 1) begin
                    inst_req = 1'b0; data_req = 1'b0; dropped = 1'b1;
                end
                bus_ready = (k == lat);
                bus_rdata = force_rd ? forced_rd : $urandom;
                if (k == lat) cap = bus_rdata;
                @(negedge clk);
                check("busy_req", 32'(bus_req), 32'h1);
                check("busy_addr", bus_addr, port_d ? da : ia);
                check("busy_we", 32'(bus_we), 32'(is_store));
                check("busy_mask", 32'(bus_wmask), is_store ? 32'(dm) : 32'h0);
                if (is_store) check("busy_wdata", bus_wdata, dwd);
                check("busy_stall", 32'(want_stall), 32'(!dropped || !last));
                check("busy_valid", {30'h0, inst_valid, data_valid}, 32'h0);
            end
            @(posedge clk); #1;
            bus_ready = 1'b0;
            @(negedge clk);
            exp_rd = (tmo || is_store) ? 32'h0 : cap;
            check("done_ivalid", 32'(inst_valid), 32'(!port_d));
            check("done_dvalid", 32'(data_valid), 32'(port_d));
            check("done_rdata", port_d ? data_rdata : inst_rdata, exp_rd);
            check("done_err", 32'(bus_error), 32'(tmo));
            check("done_breq", 32'(bus_req), 32'h0);
            check("done_stall", 32'(want_stall), 32'(!last));
            exp_txn++;
        end
    endtask

    function automatic int rand_lat();
        if ($urandom_range(0, 9) < 2) return int'($urandom_range(MAX_WAIT, MAX_WAIT + 3));
        return int'($urandom_range(0, MAX_WAIT - 1));
    endfunction

    initial begin
        bit hi, hd, seen;
        rst = 1'b1; inst_req = 1'b1; data_req = 1'b0; data_we = 1'b0; bus_ready = 1'b0;
        inst_addr = 32'h0; data_addr = 32'h0; data_wdata = 32'h0; data_wmask = 4'h0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outs", {bus_req, bus_we, inst_valid, data_valid, bus_error, bus_wmask}, 32'h0);
        check("rst_bus", bus_addr | bus_wdata | inst_rdata | data_rdata, 32'h0);
        check("rst_stall_req", 32'(want_stall), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        check("rst_stall_idle", 32'(want_stall), 32'h0);

        force_rd = 1'b1; forced_rd = 32'hDEADBEEF;
        run_op(0, 1, 32'h0, 0, 32'h100, 32'h0, 4'h0, 0, 0, 0);
        force_rd = 1'b0;
        run_op(1, 1, 32'h40, 0, 32'h180, 32'h0, 4'h0, 0, 0, 0);
        run_op(0, 1, 32'h0, 1, 32'h200, 32'hCAFEF00D, 4'b0011, 0, 3, 0);
        run_op(1, 0, 32'h300, 0, 32'h0, 32'h0, 4'h0, 20, 0, 0);
        run_op(1, 0, 32'h304, 0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
        run_op(1, 0, 32'h308, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
        run_op(0, 1, 32'h0, 0, 32'h400, 32'h0, 4'h0, 0, 2, 1);

        // Abandon a fetch with reset in its second bus cycle.
        @(posedge clk); #1;
        inst_req = 1'b1; inst_addr = 32'h500; data_req = 1'b0; bus_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy_req", 32'(bus_req), 32'h1);
        exp_txn++;
        @(posedge clk); #1;
        rst = 1'b0; inst_req = 1'b0;
        @(negedge clk);
        check("rst_abort_breq", 32'(bus_req), 32'h0);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | inst_valid | data_valid | bus_error | bus_req;
        end
        check("rst_no_valid", 32'(seen), 32'h0);
        run_op(1, 0, 32'h504, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            hi = 1'($urandom_range(0, 1));
            hd = ($urandom_range(0, 3) != 0);
            run_op(hi, hd, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                   $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
                   rand_lat(), rand_lat(), (hi ^ hd) && ($urandom_range(0, 7) == 0));
        end

        @(posedge clk); #1;
        inst_req = 1'b0; data_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bus_txn_count", 32'(bus_txn), 32'(exp_txn));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 255: bus wait-cycle limit before a transaction is aborted as a timeout.
REQ-002 Parameter DATA_FIRST, default 1: 1 = data port wins simultaneous requests; 0 = instruction port wins.
REQ-003 clock  in  1  sole clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 inst_req  in  1  fetch request; held by the requester until the pipeline advances.
REQ-006 inst_addr  in  32  fetch word address.
REQ-007 inst_rdata  out  32  fetched word; valid only while inst_valid=1.
REQ-008 inst_valid  out  1  one-cycle completion pulse for the fetch.
REQ-009 data_req  in  1  load/store request; held until the pipeline advances.
REQ-010 data_we  in  1  1 = store, 0 = load.
REQ-011 data_addr, data_wdata  in  32 each  load/store address and store data.
REQ-012 data_wmask  in  4  store byte enables.
REQ-013 data_rdata  out  32  load result; valid only while data_valid=1.
REQ-014 data_valid  out  1  one-cycle completion pulse for the data access.
REQ-015 bus_req, bus_we  out  1 each  shared memory bus request and write strobe.
REQ-016 bus_addr, bus_wdata  out  32 each  bus address and write data.
REQ-017 bus_wmask  out  4  bus byte enables.
REQ-018 bus_ready  in  1  memory completes the current access in this cycle.
REQ-019 bus_rdata  in  32  read data; sampled when bus_ready=1.
REQ-020 bus_error  out  1  one-cycle pulse, coincident with the valid of a timed-out access.
REQ-021 want_stall  out  1  pipeline stall request, driven straight into the pipeline controller's stall input.

Function
REQ-022 FSM states:
- IDLE
- BUSY_I, BUSY_D: bus owned by the instruction or data port.
- DONE_I, DONE_D: completion cycle.
REQ-023 A request is eligible when its req=1 and its served flag (inst_done / data_done) is 0.
REQ-024 IDLE: if any request is eligible, grant per DATA_FIRST, latch that port's address, data, mask and we into the bus registers, and go to BUSY_x; otherwise stay in IDLE.
REQ-025 BUSY_x drives the bus from the latched registers:
- bus_req=1.
- bus_we=1 only for a data store.
- bus_wmask=data_wmask for a store, 4'b0000 otherwise.
- Bus outputs are stable for the whole BUSY state and 0 in every other state.
REQ-026 BUSY_x with bus_ready=1: capture bus_rdata (0 for a store) and go to DONE_x.
REQ-027 BUSY_x with bus_ready=0: increment the 8-bit-minimum wait counter. When the counter equals MAX_WAIT-1, go to DONE_x with captured data=0 and an error flag set.
REQ-028 The wait counter clears on every entry to BUSY_x.
REQ-029 DONE_x: x_valid=1 and x_rdata=captured data. bus_error=error flag. Set the served flag x_done. Return to IDLE. No arbitration takes place in DONE states.
REQ-030 Minimum latency: req sampled in IDLE at cycle N, bus_req at N+1, bus_ready at N+1, valid at N+2.
REQ-031 want_stall = (data_req & !data_done & !data_valid) | (inst_req & !inst_done & !inst_valid), combinational.
REQ-032 In any cycle with want_stall=0, both served flags clear on the next edge.
REQ-033 While one flag is set and the other request is pending, the served port is never re-granted.
REQ-034 A req deasserted mid-transaction does not abort it; the transaction completes and the valid pulse still occurs.
REQ-035 Outputs other than want_stall are registered or decoded from state only; bus_ready has no combinational path to any output.

Reset
REQ-036 On reset, at the next edge:
- state=IDLE.
- Wait counter, both served flags, the error flag and all captured data are cleared.
REQ-037 After reset, all outputs are 0, except want_stall, which follows REQ-031 with cleared flags.
REQ-038 Reset during BUSY_x abandons the access: bus_req=0 from the cycle after the reset edge, and no valid or error pulse is produced.

Verification
REQ-039 Single load: data_req=1, data_we=0, addr=0x100; bus_ready=1 on the first BUSY cycle with rdata=0xDEADBEEF.
- Expected: data_valid at N+2 with data_rdata=0xDEADBEEF.
- Expected: want_stall=1 for cycles N and N+1, 0 at N+2.
REQ-040 Simultaneous inst_req and data_req, DATA_FIRST=1, bus_ready always 1.
- Expected: data granted first; inst_valid 3 cycles after data_valid.
- Expected: data not re-issued; want_stall drops on the inst_valid cycle.
REQ-041 Store with data_wmask=4'b0011 and 3 bus wait states.
- Expected: bus_we=1, bus_wmask=0011, address stable for 4 BUSY cycles, then data_valid with data_rdata=0.
REQ-042 Timeout with MAX_WAIT=4 and bus_ready held 0.
- Expected: 4 BUSY cycles, then inst_valid=1, bus_error=1, inst_rdata=0; bus_req=0 in DONE.
REQ-043 Reset asserted in the 2nd BUSY cycle.
- Expected: bus_req=0 the next cycle; no valid ever appears.
- Expected: a new request after reset completes normally.
REQ-044 Back-to-back fetches with inst_req held, 1-cycle stall release between them.
- Expected: each fetch is issued exactly once, verified by a bus transaction count.
